multdiv_issue_ctrl: RTL
=======================

# multdiv_issue_ctrl

Pipeline-side controller for the multi-cycle multiply/divide unit. It accepts MULT/DIV from the EX stage and launches them on the unit through a start/done handshake. It owns the architectural HI/LO registers and stalls the pipeline only when a later instruction depends on an operation that is still outstanding. It is the initiator/consumer end of the mult/div interface.

## Interface
Parameters:
- TIMEOUT, default 48: BUSY cycles allowed before a missing done is treated as a fault.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- ALUCtl_i  in  `ALU_CTL_BITS  EX-stage control. Recognised codes: `ALU_CTL_MULT, `ALU_CTL_DIV, `ALU_CTL_MFHI, `ALU_CTL_MFLO. All others are no-ops for this block.
- Op1_i  in  32  rs operand, signed.
- Op2_i  in  32  rt operand, signed.
- Res_o  out  32  MFHI/MFLO result; combinational; 0 for other codes.
- Stall_o  out  1  freezes the pipeline; the instruction in EX is re-presented next cycle.
- err_o  out  1  sticky timeout flag.
- md_start_o  out  1  one-cycle launch pulse to the unit; registered.
- md_op_o  out  1  0 = multiply, 1 = divide; registered; held stable while BUSY.
- md_a_o  out  32  dividend/multiplicand; registered; held stable while BUSY.
- md_b_o  out  32  divisor/multiplier; registered; held stable while BUSY.
- md_done_i  in  1  unit result valid; single-cycle pulse.
- md_hi_i  in  32  unit HI result; valid only while md_done_i is 1.
- md_lo_i  in  32  unit LO result; valid only while md_done_i is 1.

## Operation
- States: IDLE and BUSY. Registers: hi, lo, cnt (6-bit minimum, enough to hold TIMEOUT), err.
- Accepting MULT/DIV in IDLE with Stall_o=0:
  - md_a_o, md_b_o and md_op_o load from Op1_i, Op2_i and the operation.
  - md_start_o=1 on the next cycle.
  - Next state is BUSY and cnt is cleared.
  - The instruction retires immediately. No stall.
- DIV with Op2_i==0 in IDLE:
  - The unit is not launched and the state stays IDLE.
  - hi<=Op1_i and lo<=32'hFFFF_FFFF.
- BUSY:
  - cnt increments every cycle. md_done_i is sampled every BUSY cycle, including the cycle md_start_o is 1.
  - md_done_i=1: hi<=md_hi_i, lo<=md_lo_i, next state IDLE.
  - cnt==TIMEOUT-1 without md_done_i: hi<=0, lo<=0, err<=1, next state IDLE.
  - Done and timeout in the same cycle: done wins and err is not set.
- Stall_o, all combinational:
  - 1 when BUSY and ALUCtl_i is MFHI or MFLO and md_done_i=0.
  - 1 when BUSY and ALUCtl_i is MULT or DIV, regardless of md_done_i. The instruction issues on the following IDLE cycle.
  - 0 otherwise. Other codes never stall.
- Res_o:
  - MFHI gives hi; MFLO gives lo.
  - In a BUSY cycle with md_done_i=1, MFHI bypasses to md_hi_i and MFLO bypasses to md_lo_i, with Stall_o=0.
- md_done_i in IDLE is ignored, including a stale done arriving after reset.
- err_o=err; it clears only on reset.

## Timing
- Reset, on the cycle rst_i is sampled high:
  - state=IDLE; hi=lo=0; cnt=0; err=0.
  - md_start_o=0; md_op_o=0; md_a_o=md_b_o=0.
  - Stall_o is forced 0 while rst_i=1.
  - Reset during BUSY abandons the operation; the unit's later done is ignored.
- Issue latency:
  - MULT/DIV presented at cycle T gives md_start_o=1 at T+1, and BUSY from T+1.
  - Unit done at T+1+L: hi/lo are visible via bypass in that cycle and from the registers at T+2+L.
- A dependent MFHI/MFLO stalls for every BUSY cycle before done; it is released in the done cycle.
- Back-to-back MULT: the second stalls through the done cycle, is accepted in the first IDLE cycle, and its md_start_o follows one cycle later.
- Divide-by-zero: hi/lo are updated at T+1 and MFLO at T+1 returns 32'hFFFF_FFFF.
- Timeout: err_o=1 from the cycle after cnt reaches TIMEOUT-1.

## Test plan
- MULT Op1=3, Op2=-2; unit model done 33 cycles after start; MFLO presented the cycle after MULT.
  - Required: md_start_o 1 cycle after MULT; Stall_o high until the done cycle; MFLO returns 32'hFFFF_FFFA via bypass.
  - Then MFHI returns 32'hFFFF_FFFF with no stall.
- DIV 7/0, then MFHI and MFLO.
  - Required: no md_start_o; MFHI returns 7, MFLO returns 32'hFFFF_FFFF; no stall.
- MULT immediately followed by DIV 100/7, unit latency 33.
  - Required: DIV stalls through the MULT done cycle; md_start_o for DIV 2 cycles after MULT done, with md_op_o=1, md_a_o=100, md_b_o=7.
  - Final MFLO returns 14 and MFHI returns 2.
- Unit model never asserts done, TIMEOUT=48.
  - Required: err_o rises 48 cycles after start; state returns to IDLE; MFHI returns 0 with no stall.
- rst_i for 1 cycle at start+10; unit done arrives at start+33.
  - Required: all outputs reset; the late done leaves hi/lo=0; the next MULT issues normally.
- Done pulse and an add-type ALUCtl_i in the same cycle.
  - Required: Stall_o=0 and Res_o=0; hi/lo updated next cycle.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multi-cycle multiply/divide unit.
// Launches MULT/DIV over a start/done handshake, owns HI/LO, and stalls
// only instructions that depend on an operation still outstanding.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no operation outstanding; MULT/DIV accepted without stall
//   BUSY  | unit running; waiting for md_done_i or the timeout

`ifndef ALU_CTL_BITS
`define ALU_CTL_BITS 4
`endif
`ifndef ALU_CTL_MULT
`define ALU_CTL_MULT 4'd8
`endif
`ifndef ALU_CTL_DIV
`define ALU_CTL_DIV 4'd9
`endif
`ifndef ALU_CTL_MFHI
`define ALU_CTL_MFHI 4'd10
`endif
`ifndef ALU_CTL_MFLO
`define ALU_CTL_MFLO 4'd11
`endif

module multdiv_issue_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [`ALU_CTL_BITS-1:0] ALUCtl_i,
    input  logic [31:0]              Op1_i,
    input  logic [31:0]              Op2_i,
    output logic [31:0]              Res_o,
    output logic                     Stall_o,
    output logic                     err_o,
    output logic                     md_start_o,
    output logic                     md_op_o,
    output logic [31:0]              md_a_o,
    output logic [31:0]              md_b_o,
    input  logic                     md_done_i,
    input  logic [31:0]              md_hi_i,
    input  logic [31:0]              md_lo_i
);

    localparam int CW = ($clog2(TIMEOUT) > 6) ? $clog2(TIMEOUT) : 6;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [31:0]   hi, lo;
    logic [CW-1:0] cnt;
    logic          err;

    logic is_mult, is_div, is_mfhi, is_mflo, is_md;
    logic div_zero, launch, take_done, tmo;

    assign is_mult   = (ALUCtl_i == `ALU_CTL_BITS'(`ALU_CTL_MULT));
    assign is_div    = (ALUCtl_i == `ALU_CTL_BITS'(`ALU_CTL_DIV));
    assign is_mfhi   = (ALUCtl_i == `ALU_CTL_BITS'(`ALU_CTL_MFHI));
    assign is_mflo   = (ALUCtl_i == `ALU_CTL_BITS'(`ALU_CTL_MFLO));
    assign is_md     = is_mult | is_div;

    // Divide by zero never reaches the unit; HI/LO are written directly.
    assign div_zero  = (state == IDLE) && is_div && (Op2_i == 32'd0);
    assign launch    = (state == IDLE) && is_md && !(is_div && (Op2_i == 32'd0));
    assign take_done = (state == BUSY) && md_done_i;
    // Done in the same cycle as the last allowed count takes priority.
    assign tmo       = (state == BUSY) && !md_done_i && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = BUSY;
            BUSY:    if (take_done || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Launch registers, timeout counter, HI/LO and the sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            md_start_o <= 1'b0;
            md_op_o    <= 1'b0;
            md_a_o     <= 32'd0;
            md_b_o     <= 32'd0;
            cnt        <= '0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            err        <= 1'b0;
        end else begin
            md_start_o <= launch;
            if (launch) begin
                md_op_o <= is_div;
                md_a_o  <= Op1_i;
                md_b_o  <= Op2_i;
                cnt     <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
            if (div_zero) begin
                hi <= Op1_i;
                lo <= 32'hFFFF_FFFF;
            end else if (take_done) begin
                hi <= md_hi_i;
                lo <= md_lo_i;
            end else if (tmo) begin
                hi  <= 32'd0;
                lo  <= 32'd0;
                err <= 1'b1;
            end
        end
    end

    assign err_o = err;

    // Stall and result outputs; the done cycle bypasses the unit result.
    always_comb begin
        Stall_o = 1'b0;
        Res_o   = 32'd0;
        if (!rst_i && state == BUSY) begin
            if (is_md)                          Stall_o = 1'b1;
            else if ((is_mfhi || is_mflo) && !md_done_i) Stall_o = 1'b1;
        end
        if (is_mfhi)      Res_o = take_done ? md_hi_i : hi;
        else if (is_mflo) Res_o = take_done ? md_lo_i : lo;
    end

endmodule
